// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family: FSM state encoding
// and the grant-ID width helper used when N comes from a parent level.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Never returns 0, so a one-requester or MAX_HOLD=1 build still gets a real vector.
  function automatic int arb_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first eligible requester at or above ptr,
// wrapping mod N. Masked bits are never picked.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] pick_id,
  output logic            any
);

  logic [N-1:0]    eligible;
  logic [ID_W-1:0] idx;

  assign eligible = req & ~mask;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = ID_W'((int'(ptr) + i) % N);
      if (!any && eligible[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with registered one-hot grant and owner ID.
// Define ARB_TIMEOUT_EN to pre-empt an owner after MAX_HOLD cycles while others wait.
//
// state     | meaning
// ARB_IDLE  | no owner; any request is granted from ptr upward
// ARB_GRANT | owner gnt_id holds the resource until it drops its request
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = arb_id_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  if (N < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arbiter_param: N must be >= 2 and MAX_HOLD >= 1");
  end

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic            gnt_valid_q, gnt_valid_d;

  logic [ID_W-1:0] nxt_ptr, pick_ptr, pick_id;
  logic [N-1:0]    pick_mask, pick;
  logic            pick_any, owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = arb_id_w(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_sat;
  assign hold_sat = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

  assign nxt_ptr   = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + ID_W'(1);
  assign owner_req = |(req & gnt_q);
  // While owned, search starts just past the owner and skips it, which serves
  // both release and pre-emption with a single picker.
  assign pick_ptr  = (state_q == ARB_GRANT) ? nxt_ptr : ptr_q;
  assign pick_mask = (state_q == ARB_GRANT) ? gnt_q : '0;

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req     (req),
    .mask    (pick_mask),
    .ptr     (pick_ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_GRANT;
          gnt_d       = pick;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d      = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!owner_req) begin
          ptr_d = nxt_ptr;
`ifdef ARB_TIMEOUT_EN
          hold_d = '0;
`endif
          if (pick_any) begin
            gnt_d    = pick;
            gnt_id_d = pick_id;
          end else begin
            state_d     = ARB_IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_sat && pick_any) begin
          ptr_d    = nxt_ptr;
          gnt_d    = pick;
          gnt_id_d = pick_id;
          hold_d   = '0;
        end else if (!hold_sat) begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised round-robin arbiter; successor to the fixed 4-requester arbiter.
- Shares one resource among N requesters and holds the grant while the owner keeps requesting.
- Optionally pre-empts an owner that holds too long while others wait.
- Sits between request sources and a shared bus/resource; outputs are registered one-hot grants plus an encoded owner ID.

Parameters:
- N, 4, number of requesters; legal range N >= 2.
- ID_W, $clog2(N), width of gnt_id; derived, not overridden.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation (used only with ARB_TIMEOUT_EN); legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req  input  N  request vector; bit i = requester i.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  registered; 1 when any gnt bit is set.
- gnt_id  output  ID_W  registered index of the granted requester; 0 when idle.

Behaviour:
- Reset (reset=0, asynchronous): gnt=0, gnt_valid=0, gnt_id=0, state=IDLE, ptr=0, hold_cnt=0. Requester 0 has top priority after reset.
- All outputs are flops; no combinational path from req to gnt. Grant latency is 1 cycle: req sampled at edge k, gnt visible after edge k.
- Pick rule: the first requester set in req, searched from ptr upward and wrapping mod N.
- State IDLE:
  - req==0: stay in IDLE, outputs 0.
  - Otherwise: grant the pick, go to GRANT, hold_cnt=0.
- State GRANT (owner o):
  - req[o]=1 and no pre-emption: keep the grant; hold_cnt increments and saturates at MAX_HOLD-1.
  - req[o]=0: release. ptr=(o+1) mod N.
    - If other requests are pending, grant the pick from the new ptr at the same edge. Zero-bubble handover: gnt goes directly from one-hot o to one-hot p.
    - Otherwise go to IDLE with gnt=0.
- ptr updates only on release or pre-emption, always to (previous owner + 1) mod N, with wrap from N-1 to 0.
- Simultaneous requests: exactly one grant; gnt is never multi-hot.
- Mid-grant reset: outputs clear immediately (asynchronously), without waiting for a clock edge; arbitration restarts with ptr=0.
- A request that drops before it is granted is simply not considered; there is no request memory.
- Starvation bound: each requester is granted within N-1 ownerships of others; with ARB_TIMEOUT_EN this is also bounded in cycles.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD-1, req[o]=1 and (req with bit o masked) != 0: pre-empt.
  - Pre-emption grants the pick from ptr=(o+1) mod N, sets ptr accordingly and clears hold_cnt.
  - If no other request is pending, the owner keeps the grant and hold_cnt stays saturated.
- Undefined:
  - Ownership lasts until req[o] drops.
  - hold_cnt logic is absent (not merely unused).
  - MAX_HOLD is ignored.

Decomposition:
- Shared package arb_pkg:
  - State encoding: ARB_IDLE=1'b0, ARB_GRANT=1'b1.
  - A function for ID width, used when N is passed from a top level.
- One natural sub-module, rr_pick:
  - Combinational rotate-priority-encode.
  - Inputs: req, mask, ptr. Outputs: one-hot pick, pick_id, any.
  - Instantiated once in the arbiter; reusable by future weighted arbiters.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles with req=4'b1111 → gnt=0000, gnt_valid=0, gnt_id=0. Release reset with req=0000 → outputs stay 0.
- Single request hold: req=0100 for 5 cycles, then 0000 → gnt=0100 and gnt_id=2 from 1 cycle after req until 1 cycle after drop, then 0000.
- Round robin (N=4, ARB_TIMEOUT_EN off):
  - req=1111, each owner drops its own bit for one cycle after being granted 2 cycles.
  - Required grant order: 0001, 0010, 0100, 1000, 0001.
  - Every handover is zero-bubble.
- Wrap and skip: after owner 3 releases with req=0101 → grant 0001. After owner 0 releases with req=0100 → grant 0100.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=3):
  - req=0011 held constantly → gnt alternates 0001 ×3 cycles, 0010 ×3 cycles, repeating.
  - With req=0001 only → gnt=0001 indefinitely.
- Async reset mid-grant: owner 2 granted; drop reset between clock edges → gnt=0000 before the next edge. After release with req=1111 → first grant is 0001.
- Parametrisation: rerun the round-robin scenario at N=2 and N=7 → order 0..N-1 with wrap; gnt_id widths 1 and 3.
